tx_sample_pacer: RTL and testbench

//  Downstream consumer of the sys_ctrl TX settings (o_tx_sample_gap, o_tx_control_word).

---
 rtl/tx_sample_pacer.sv | 128 ++++++++++++
 tb/tb_tx_sample_pacer.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tx_sample_pacer.sv
// TX sample pacer: pulls words from the TX FIFO, presents them to the serializer over
// valid/ready, inserts programmable idle gaps and counts FIFO underruns.
module tx_sample_pacer #(
    parameter int unsigned SAMPLE_W = 32,
    parameter int unsigned GAP_W    = 4,
    parameter int unsigned CNT_W    = 16
) (
    input  logic                i_sys_clk,
    input  logic                i_rst,
    input  logic [GAP_W-1:0]    i_tx_sample_gap,
    input  logic [7:0]          i_tx_control_word,
    input  logic                i_fifo_empty,
    input  logic [SAMPLE_W-1:0] i_fifo_data,
    output logic                o_fifo_pull,
    output logic [SAMPLE_W-1:0] o_sample,
    output logic                o_sample_valid,
    input  logic                i_sample_ready,
    output logic [CNT_W-1:0]    o_underrun_count,
    output logic                o_busy
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        PULL    = 3'd1,
        LATCH   = 3'd2,
        PRESENT = 3'd3,
        GAP     = 3'd4
    } state_t;

    state_t             state;
    logic [GAP_W-1:0]   gap_cnt;
    logic [CNT_W-1:0]   underrun_cnt;
    logic               src_fifo;
    logic               stall_seen;

    logic enable;
    logic zero_fill;
    logic cnt_clear;
    logic cnt_max;
    logic underrun_evt;
    logic handshake;

    assign enable    = i_tx_control_word[0];
    assign zero_fill = i_tx_control_word[1];
    assign cnt_clear = i_tx_control_word[2];
    assign cnt_max   = (underrun_cnt == {CNT_W{1'b1}});
    assign handshake = o_sample_valid && i_sample_ready;

    // A stall counts once; zero-fill counts every substituted sample.
    assign underrun_evt = (state == PULL) && enable && i_fifo_empty
                          && (zero_fill || !stall_seen);

    // Pop strobe is decoded in the PULL cycle so read data lands during LATCH.
    assign o_fifo_pull      = (state == PULL) && enable && !i_fifo_empty && !i_rst;
    assign o_busy           = (state != IDLE);
    assign o_underrun_count = underrun_cnt;

    always_ff @(posedge i_sys_clk) begin
        if (i_rst) begin
            state          <= IDLE;
            o_sample       <= '0;
            o_sample_valid <= 1'b0;
            gap_cnt        <= '0;
            underrun_cnt   <= '0;
            src_fifo       <= 1'b0;
            stall_seen     <= 1'b0;
        end else begin
            if (cnt_clear) begin
                underrun_cnt <= '0;
            end else if (underrun_evt && !cnt_max) begin
                underrun_cnt <= underrun_cnt + CNT_W'(1);
            end

            case (state)
                IDLE: begin
                    if (enable) begin
                        state <= PULL;
                    end
                end
                PULL: begin
                    if (!enable) begin
                        state      <= IDLE;
                        stall_seen <= 1'b0;
                    end else if (!i_fifo_empty) begin
                        src_fifo   <= 1'b1;
                        stall_seen <= 1'b0;
                        state      <= LATCH;
                    end else if (zero_fill) begin
                        src_fifo   <= 1'b0;
                        stall_seen <= 1'b0;
                        state      <= LATCH;
                    end else begin
                        stall_seen <= 1'b1;
                    end
                end
                LATCH: begin
                    o_sample       <= src_fifo ? i_fifo_data : '0;
                    o_sample_valid <= 1'b1;
                    state          <= PRESENT;
                end
                PRESENT: begin
                    // Enable is deliberately ignored so a presented sample always completes.
                    if (handshake) begin
                        o_sample_valid <= 1'b0;
                        gap_cnt        <= i_tx_sample_gap;
                        if (i_tx_sample_gap == '0) begin
                            state <= PULL;
                        end else begin
                            state <= GAP;
                        end
                    end
                end
                GAP: begin
                    if ((gap_cnt == GAP_W'(1)) || (gap_cnt == '0)) begin
                        state <= PULL;
                    end else begin
                        gap_cnt <= gap_cnt - GAP_W'(1);
                    end
                end
                default: begin
                    state          <= IDLE;
                    o_sample_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_tx_sample_pacer.sv
// Scoreboard bench for tx_sample_pacer: FIFO model with registered read, expected samples
// queued as stimulus is pushed and compared at each valid/ready handshake.
module tb_tx_sample_pacer;

    localparam int unsigned SW = 32;
    localparam int unsigned GW = 4;
    localparam int unsigned CW = 16;

    logic          clk = 1'b0;
    logic          rst;
    logic [GW-1:0] gap;
    logic [7:0]    ctrl;
    logic          fifo_empty;
    logic [SW-1:0] fifo_data = '0;
    logic          fifo_pull;
    logic [SW-1:0] sample;
    logic          sample_valid;
    logic          ready;
    logic [CW-1:0] ucnt;
    logic          busy;

    always #5 clk = ~clk;

    tx_sample_pacer #(.SAMPLE_W(SW), .GAP_W(GW), .CNT_W(CW)) dut (
        .i_sys_clk        (clk),
        .i_rst            (rst),
        .i_tx_sample_gap  (gap),
        .i_tx_control_word(ctrl),
        .i_fifo_empty     (fifo_empty),
        .i_fifo_data      (fifo_data),
        .o_fifo_pull      (fifo_pull),
        .o_sample         (sample),
        .o_sample_valid   (sample_valid),
        .i_sample_ready   (ready),
        .o_underrun_count (ucnt),
        .o_busy           (busy)
    );

    // FIFO model: data appears the cycle after the pull strobe.
    logic [SW-1:0] fifo_mem [64];
    logic [5:0]    wr_ptr = '0;
    logic [5:0]    rd_ptr = '0;
    assign fifo_empty = (wr_ptr == rd_ptr);

    always @(posedge clk) begin
        if (fifo_pull) begin
            fifo_data <= fifo_mem[rd_ptr];
            rd_ptr    <= rd_ptr + 6'd1;
        end
    end

    logic [SW-1:0] exp_q [$];
    int            hs_t [$];
    int            cyc = 0;
    int            hs_n = 0;
    int            pull_n = 0;
    logic          prev_pull = 1'b0;
    int            vectors = 0;
    int            miscompares = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        cyc++;
        if (fifo_pull) begin
            pull_n++;
            check("pull_back_to_back", 32'(prev_pull), 32'd0);
        end
        prev_pull = fifo_pull;
        if (sample_valid && ready) begin
            hs_t.push_back(cyc);
            hs_n++;
            if (exp_q.size() == 0) begin
                check("sb_unexpected_sample", 32'(exp_q.size()), 32'd1);
            end else begin
                check("sample", sample, exp_q.pop_front());
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic push_word(input logic [SW-1:0] w, input bit expect_it);
        fifo_mem[wr_ptr] = w;
        wr_ptr = wr_ptr + 6'd1;
        if (expect_it) exp_q.push_back(w);
    endtask

    task automatic new_test();
        hs_t.delete();
        hs_n   = 0;
        pull_n = 0;
    endtask

    task automatic wait_hs(input int n, input int budget);
        int k = 0;
        while (hs_n < n && k < budget) begin
            tick(1);
            k++;
        end
        check("hs_timeout", 32'(hs_n >= n), 32'd1);
    endtask

    task automatic wait_valid(input int budget);
        int k = 0;
        while (!sample_valid && k < budget) begin
            tick(1);
            k++;
        end
        check("valid_timeout", 32'(sample_valid), 32'd1);
    endtask

    task automatic wait_idle(input int budget);
        int k = 0;
        while (busy && k < budget) begin
            tick(1);
            k++;
        end
        check("idle_timeout", 32'(busy), 32'd0);
    endtask

    initial begin
        rst   = 1'b1;
        ctrl  = 8'h00;
        gap   = '0;
        ready = 1'b1;
        tick(2);
        check("rst_sample", sample, 32'd0);
        check("rst_valid", 32'(sample_valid), 32'd0);
        check("rst_pull", 32'(fifo_pull), 32'd0);
        check("rst_count", 32'(ucnt), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        rst = 1'b0;
        tick(1);

        // back-to-back FIFO samples, gap 0
        new_test();
        push_word(32'h11111111, 1'b1);
        push_word(32'h22222222, 1'b1);
        push_word(32'h33333333, 1'b1);
        ctrl = 8'h01;
        wait_hs(3, 40);
        check("t1_spacing0", 32'(hs_t[1] - hs_t[0]), 32'd3);
        check("t1_spacing1", 32'(hs_t[2] - hs_t[1]), 32'd3);
        check("t1_pulls", 32'(pull_n), 32'd3);
        check("t1_count", 32'(ucnt), 32'd0);
        ctrl = 8'h00;
        wait_idle(20);

        // gap of 5 idle cycles; reserved control bits set
        new_test();
        gap = 4'd5;
        push_word(32'hA0000001, 1'b1);
        push_word(32'hA0000002, 1'b1);
        push_word(32'hA0000003, 1'b1);
        ctrl = 8'hF9;
        wait_hs(3, 60);
        check("t2_spacing0", 32'(hs_t[1] - hs_t[0]), 32'd8);
        check("t2_spacing1", 32'(hs_t[2] - hs_t[1]), 32'd8);
        check("t2_pulls", 32'(pull_n), 32'd3);
        check("t2_count", 32'(ucnt), 32'd0);
        ctrl = 8'h00;
        gap  = '0;
        wait_idle(20);

        // backpressure while PRESENT
        new_test();
        ready = 1'b0;
        push_word(32'hCAFE0001, 1'b1);
        push_word(32'hCAFE0002, 1'b1);
        ctrl = 8'h01;
        wait_valid(20);
        for (int i = 0; i < 4; i++) begin
            check("t3_valid_held", 32'(sample_valid), 32'd1);
            check("t3_sample_stable", sample, 32'hCAFE0001);
            tick(1);
        end
        check("t3_pulls_stalled", 32'(pull_n), 32'd1);
        ready = 1'b1;
        tick(1);
        check("t3_pull_after_hs", 32'(fifo_pull), 32'd1);
        wait_hs(2, 20);
        ctrl = 8'h00;
        wait_idle(20);
        check("t3_pulls", 32'(pull_n), 32'd2);
        check("t3_count", 32'(ucnt), 32'd0);

        // zero-fill underrun, then stall, then resume
        new_test();
        for (int i = 0; i < 3; i++) exp_q.push_back(32'h0);
        ctrl = 8'h03;
        wait_hs(3, 40);
        check("t4_zf_spacing0", 32'(hs_t[1] - hs_t[0]), 32'd3);
        check("t4_zf_spacing1", 32'(hs_t[2] - hs_t[1]), 32'd3);
        check("t4_zf_count", 32'(ucnt), 32'd3);
        ctrl = 8'h01;
        tick(6);
        check("t4_stall_valid", 32'(sample_valid), 32'd0);
        check("t4_stall_count", 32'(ucnt), 32'd4);
        push_word(32'h5A5A5A5A, 1'b1);
        wait_hs(4, 20);
        check("t4_resume_count", 32'(ucnt), 32'd4);
        ctrl = 8'h00;
        wait_idle(20);

        // disable while PRESENT: sample still completes
        new_test();
        ready = 1'b0;
        push_word(32'hC0C0C0C0, 1'b1);
        push_word(32'hD0D0D0D0, 1'b0);
        ctrl = 8'h01;
        wait_valid(20);
        ctrl = 8'h00;
        tick(2);
        check("t5_valid_held", 32'(sample_valid), 32'd1);
        check("t5_sample", sample, 32'hC0C0C0C0);
        check("t5_busy", 32'(busy), 32'd1);
        ready = 1'b1;
        wait_hs(1, 10);
        wait_idle(10);
        tick(3);
        check("t5_pulls", 32'(pull_n), 32'd1);
        check("t5_busy_after", 32'(busy), 32'd0);
        check("t5_valid_after", 32'(sample_valid), 32'd0);

        // reset during LATCH discards the popped word
        new_test();
        ctrl = 8'h01;
        begin
            int k = 0;
            while (!fifo_pull && k < 20) begin
                tick(1);
                k++;
            end
        end
        check("t6_pull_seen", 32'(fifo_pull), 32'd1);
        tick(1);
        check("t6_busy_latch", 32'(busy), 32'd1);
        rst  = 1'b1;
        ctrl = 8'h00;
        tick(1);
        check("t6_rst_sample", sample, 32'd0);
        check("t6_rst_valid", 32'(sample_valid), 32'd0);
        check("t6_rst_pull", 32'(fifo_pull), 32'd0);
        check("t6_rst_count", 32'(ucnt), 32'd0);
        check("t6_rst_busy", 32'(busy), 32'd0);
        rst = 1'b0;
        tick(2);
        check("t6_no_sample", 32'(hs_n), 32'd0);

        // counter saturation, then clear
        force dut.underrun_cnt = 16'hFFFC;
        tick(1);
        release dut.underrun_cnt;
        tick(1);
        check("t6_preset", 32'(ucnt), 32'h0000FFFC);
        new_test();
        for (int i = 0; i < 5; i++) exp_q.push_back(32'h0);
        ctrl = 8'h03;
        wait_hs(5, 40);
        check("t6_saturate", 32'(ucnt), 32'h0000FFFF);
        ctrl = 8'h05;
        tick(2);
        check("t6_clear", 32'(ucnt), 32'd0);
        check("t6_clear_valid", 32'(sample_valid), 32'd0);
        ctrl = 8'h00;
        wait_idle(20);

        check("sb_leftover", 32'(exp_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
